alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised N-bit sequential ALU for the multi-cycle datapath; successor to the single-cycle ALU.
//  Adds EOR, shifts and an iterative multiply, with registered outputs and a valid/ready input handshake.
//  Produces ARM-style NZCV flags. Sits between the register-file read stage and the writeback mux.
// PARAMETERS
//  N   32   operand/result width; power of two, >= 4
// PORTS
//  clk         in   1   single clock, rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  flush       in   1   synchronous abort of any in-flight op
//  in_valid    in   1   operands/op valid
//  in_ready    out  1   unit can accept (comb: state==IDLE)
//  alu_op      in   4   alu_op_t opcode
//  a, b        in   N   operands
//  out_valid   out  1   one-cycle pulse: result/flags valid (no backpressure)
//  result      out  N   registered result
//  alu_flags   out  4   {N,Z,C,V}, registered with result
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; out_valid=0; result=0; alu_flags=0; mul counter=0. in_ready=1, but no accept while reset_n=0.
//  - Accept = in_valid & in_ready at a rising edge. flush=1 blocks accept in that cycle (flush wins).
//  - Opcodes: 0 ADD, 1 SUB (a-b), 2 AND, 3 ORR, 4 EOR, 5 MOV (=b), 6 LSL, 7 LSR, 8 ASR, 9 MUL;
//    10-15 reserved: result=0, flags from result, C=V=0.
//  - Shift amount = b[$clog2(N)-1:0]. C = last bit shifted out; amount 0 -> C=0. V=0.
//  - ADD/SUB: computed at N+1 bits. SUB = a + ~b + 1; C = carry out (1 = no borrow). V: ADD -> a[N-1]==b[N-1] & r[N-1]!=a[N-1];
//    SUB -> a[N-1]!=b[N-1] & r[N-1]!=a[N-1].
//  - N = result[N-1] and Z = (result==0) for every op. C=V=0 for logic, MOV, MUL.
//  - Single-cycle ops: state stays IDLE; result/flags registered at accept edge; out_valid high the following cycle.
//    Back-to-back accepts allowed, throughput 1/cycle.
//  - MUL: accept -> state MUL, in_ready=0. Shift-add over N iterations, one bit of b per cycle (LSB first).
//    Low N bits of product only. Accept at edge k -> result/flags registered and out_valid high after edge k+N; state IDLE same edge.
//  - flush in MUL: -> IDLE next edge, no out_valid, result/flags hold previous values.
//    flush in IDLE: suppresses accept; an out_valid already registered is not cancelled.
//  - Async reset mid-MUL: immediate IDLE, outputs zeroed, partial product discarded.
//  - result/alu_flags hold their value between out_valid pulses.
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined:   opcode 9 = iterative multiply as above; alu_mul_iter instantiated.
//  ALU_SEQ_MUL_EN undefined: opcode 9 behaves as reserved (1-cycle, result=0, flags 4'b0100).
//    No MUL state or counter is built.
// STRUCTURE
//  alu_pkg:
//    - alu_op_t (4-bit enum)
//    - state_t {IDLE, MUL}
//    - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
//  Sub-module alu_mul_iter #(N): start/flush in, busy/done out, $clog2(N)+1-bit counter, partial-product register.
//  Top holds the comb single-cycle datapath, flag logic, state register and output registers.
// TESTING  (N=8 unless noted)
//  1. ADD a=0x7F b=0x01 -> result=0x80, flags=4'b1001, out_valid 1 cycle after accept.
//  2. SUB a=0x05 b=0x05 -> 0x00, flags=4'b0110. SUB a=0x00 b=0x01 -> 0xFF, flags=4'b1000.
//  3. LSL a=0x81 b=1 -> 0x02, flags=4'b0010.
//     ASR a=0x80 b=7 -> 0xFF, flags=4'b1000.
//     LSR a=0x01 b=0 -> 0x01, flags=4'b0000.
//  4. MUL a=13 b=11 (MUL_EN) -> in_ready=0 for 8 cycles; result=0x8F, flags=4'b1000, out_valid 8 edges after accept.
//     Next op accepted the same cycle in_ready returns.
//  5. MUL then flush 3 cycles after accept -> no out_valid, result unchanged, in_ready=1 next cycle.
//     Repeat with reset_n pulsed low instead -> result=0, flags=0.
//  6. Streaming: ADD, EOR, MOV on consecutive cycles -> three consecutive out_valid pulses, in order.
//     Without ALU_SEQ_MUL_EN, MUL 13*11 -> 0x00, flags=4'b0100, 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, control states and flag bit positions.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_ORR = 4'd3,
    OP_EOR = 4'd4,
    OP_MOV = 4'd5,
    OP_LSL = 4'd6,
    OP_LSR = 4'd7,
    OP_ASR = 4'd8,
    OP_MUL = 4'd9
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first, low N product bits only.
// Built only when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_mul_iter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         flush,
  input  logic [N-1:0] mcand,
  input  logic [N-1:0] mplier,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product
);

  localparam int CW = $clog2(N) + 1;

  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;

  // The last iteration is folded into the product output so the caller can register it on the final edge.
  assign busy    = (count_q != '0);
  assign done    = (count_q == CW'(1));
  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (flush) begin
      count_d = '0;
    end else if (start) begin
      count_d  = CW'(N);
      acc_d    = '0;
      mcand_d  = mcand;
      mplier_d = mplier;
    end else if (busy) begin
      count_d  = count_q - CW'(1);
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// N-bit sequential ALU with registered result/NZCV flags and a valid/ready input handshake.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier for opcode 9; otherwise opcode 9 is reserved.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alu_op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic [N-1:0] result,
  output logic [3:0]   alu_flags
);

  localparam int SW = $clog2(N);

  alu_op_t       op;
  logic [SW-1:0] sh;
  logic [N:0]    wide;
  logic [N-1:0]  comb_res;
  logic          comb_c, comb_v;
  logic [3:0]    comb_flags;
  logic          accept;

  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  result_q, result_d;
  logic [3:0]    flags_q, flags_d;

  assign op = alu_op_t'(alu_op);
  assign sh = b[SW-1:0];

  // Shifts run at N+1 bits so the last bit shifted out lands in a fixed position (0 when amount is 0).
  always_comb begin
    wide     = '0;
    comb_res = '0;
    comb_c   = 1'b0;
    comb_v   = 1'b0;
    case (op)
      OP_ADD: begin
        wide     = {1'b0, a} + {1'b0, b};
        comb_res = wide[N-1:0];
        comb_c   = wide[N];
        comb_v   = (a[N-1] == b[N-1]) && (comb_res[N-1] != a[N-1]);
      end
      OP_SUB: begin
        wide     = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        comb_res = wide[N-1:0];
        comb_c   = wide[N];
        comb_v   = (a[N-1] != b[N-1]) && (comb_res[N-1] != a[N-1]);
      end
      OP_AND: comb_res = a & b;
      OP_ORR: comb_res = a | b;
      OP_EOR: comb_res = a ^ b;
      OP_MOV: comb_res = b;
      OP_LSL: begin
        wide     = {1'b0, a} << sh;
        comb_res = wide[N-1:0];
        comb_c   = wide[N];
      end
      OP_LSR: begin
        wide     = {a, 1'b0} >> sh;
        comb_res = wide[N:1];
        comb_c   = wide[0];
      end
      OP_ASR: begin
        wide     = $signed({a, 1'b0}) >>> sh;
        comb_res = wide[N:1];
        comb_c   = wide[0];
      end
      default: comb_res = '0;
    endcase
  end

  assign comb_flags = pack_flags(comb_res[N-1], comb_res == '0, comb_c, comb_v);
  assign accept     = in_valid && in_ready && !flush;

`ifdef ALU_SEQ_MUL_EN
  state_t       state_q, state_d;
  logic         mul_start, mul_busy, mul_done;
  logic [N-1:0] mul_product;

  assign in_ready  = (state_q == IDLE);
  assign mul_start = accept && (op == OP_MUL);

  alu_mul_iter #(.N(N)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start),
    .flush   (flush),
    .mcand   (a),
    .mplier  (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Flush beats completion: an aborted multiply never produces out_valid and leaves the outputs untouched.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    flags_d     = flags_q;
    if (state_q == MUL) begin
      if (flush || !mul_busy) begin
        state_d = IDLE;
      end else if (mul_done) begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        result_d    = mul_product;
        flags_d     = pack_flags(mul_product[N-1], mul_product == '0, 1'b0, 1'b0);
      end
    end else if (mul_start) begin
      state_d = MUL;
    end else if (accept) begin
      out_valid_d = 1'b1;
      result_d    = comb_res;
      flags_d     = comb_flags;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign in_ready = 1'b1;

  always_comb begin
    out_valid_d = 1'b0;
    result_d    = result_q;
    flags_d     = flags_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = comb_res;
      flags_d     = comb_flags;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign alu_flags = flags_q;

endmodule
